// File: rtl/sys_feeder.sv
`default_nettype none
// ==== sys_feeder : skews weight/feature vector tiles into a diagonal wavefront ====
// ==== for a SysDimension x SysDimension systolic array.          rev 1.0    ====
module sys_feeder #(
  parameter int dataWidth    = 32,
  parameter int SysDimension = 32,
  parameter int featureLen   = 128
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [dataWidth*SysDimension-1:0] in_weight,
  input  logic [dataWidth*SysDimension-1:0] in_feature,
  output logic                              enable,
  output logic [dataWidth*SysDimension-1:0] weightArray,
  output logic [dataWidth*SysDimension-1:0] featureArray,
  output logic                              busy,
  output logic                              done
);

  localparam int c_CNT_W     = (featureLen > 1) ? $clog2(featureLen) : 1;
  localparam int c_FLUSH_LEN = 2 * SysDimension - 1;
  localparam int c_FCNT_W    = (c_FLUSH_LEN > 1) ? $clog2(c_FLUSH_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic [c_FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic                 enable_q;
  logic                 advance;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      fcnt_q   <= '0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      enable_q <= advance;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fcnt_d   = fcnt_q;
    advance  = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          cnt_d   = '0;
          fcnt_d  = '0;
        end
      end
      STREAM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          advance = 1'b1;
          if (cnt_q == c_CNT_W'(featureLen - 1)) begin
            state_d = FLUSH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        // Zero vectors push the last real data through the deepest lane.
        advance = 1'b1;
        if (fcnt_q == c_FCNT_W'(c_FLUSH_LEN - 1)) begin
          state_d = DONE;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign enable = enable_q;
  assign busy   = (state_q == STREAM) || (state_q == FLUSH);
  assign done   = (state_q == DONE);

  for (genvar k = 0; k < SysDimension; k++) begin : g_lane
    logic [dataWidth-1:0] w_in, f_in;
    logic [dataWidth-1:0] w_out_q, f_out_q;

    assign w_in = (state_q == STREAM) ? in_weight[k*dataWidth +: dataWidth]  : '0;
    assign f_in = (state_q == STREAM) ? in_feature[k*dataWidth +: dataWidth] : '0;

    if (k == 0) begin : g_direct
      always_ff @(posedge clk) begin
        if (!rst) begin
          w_out_q <= '0;
          f_out_q <= '0;
        end else if (advance) begin
          w_out_q <= w_in;
          f_out_q <= f_in;
        end
      end
    end else begin : g_delay
      logic [dataWidth-1:0] w_dly_q [0:k-1];
      logic [dataWidth-1:0] f_dly_q [0:k-1];

      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int i = 0; i < k; i++) begin
            w_dly_q[i] <= '0;
            f_dly_q[i] <= '0;
          end
          w_out_q <= '0;
          f_out_q <= '0;
        end else if (advance) begin
          w_dly_q[0] <= w_in;
          f_dly_q[0] <= f_in;
          for (int i = 1; i < k; i++) begin
            w_dly_q[i] <= w_dly_q[i-1];
            f_dly_q[i] <= f_dly_q[i-1];
          end
          w_out_q <= w_dly_q[k-1];
          f_out_q <= f_dly_q[k-1];
        end
      end
    end

    assign weightArray[k*dataWidth +: dataWidth]  = w_out_q;
    assign featureArray[k*dataWidth +: dataWidth] = f_out_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_sys_feeder.sv
`default_nettype none
// ==== tb_sys_feeder : directed self-checking bench for sys_feeder (8b x 4 lanes x 4 vectors) ====
module tb_sys_feeder;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_weight;
  logic [31:0] in_feature;
  logic        enable;
  logic [31:0] weightArray;
  logic [31:0] featureArray;
  logic        busy;
  logic        done;

  int tests_run;
  int tests_failed;

  sys_feeder #(
    .dataWidth   (8),
    .SysDimension(4),
    .featureLen  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_weight   (in_weight),
    .in_feature  (in_feature),
    .enable      (enable),
    .weightArray (weightArray),
    .featureArray(featureArray),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Input vector n: lane k = 16*n+k; the feature copy has bit 7 set to tell the buses apart.
  function automatic logic [31:0] mkvec(input int n, input bit feat);
    logic [31:0] v;
    logic [7:0]  e;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      e = 8'(16 * n + k) ^ (feat ? 8'h80 : 8'h00);
      v[k*8 +: 8] = e;
    end
    return v;
  endfunction

  // Output at enable pulse p: lane k carries vector p-k when that vector exists, else zero.
  function automatic logic [31:0] exp_vec(input int p, input bit feat);
    logic [31:0] v;
    logic [7:0]  e;
    int          n;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      n = p - k;
      if (n >= 0 && n <= 3) begin
        e = 8'(16 * n + k) ^ (feat ? 8'h80 : 8'h00);
        v[k*8 +: 8] = e;
      end
    end
    return v;
  endfunction

  task automatic run_tile(input int gap, input bit poke_start);
    int n, p, cyc, gapleft;
    bit acc, got_done;
    n = 0; p = 0; cyc = 0; gapleft = gap; got_done = 1'b0;
    start = 1'b1; in_valid = 1'b0;
    tick();
    start = poke_start;
    check("stream_in_ready", {31'd0, in_ready}, 32'd1);
    check("stream_busy", {31'd0, busy}, 32'd1);
    while (!got_done && cyc < 40) begin
      cyc++;
      if (n == 2 && gapleft > 0) begin
        in_valid = 1'b0; in_weight = 32'hDEADBEEF; in_feature = 32'hCAFEF00D;
        gapleft--;
      end else if (n < 4) begin
        in_valid = 1'b1; in_weight = mkvec(n, 1'b0); in_feature = mkvec(n, 1'b1);
      end else begin
        in_valid = 1'b1; in_weight = 32'hA5A5A5A5; in_feature = 32'h5A5A5A5A;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) n++;
      if (enable) begin
        check($sformatf("weight_p%0d", p), weightArray, exp_vec(p, 1'b0));
        check($sformatf("feature_p%0d", p), featureArray, exp_vec(p, 1'b1));
        p++;
      end else begin
        check($sformatf("weight_hold_p%0d", p), weightArray, exp_vec(p - 1, 1'b0));
        check($sformatf("feature_hold_p%0d", p), featureArray, exp_vec(p - 1, 1'b1));
      end
      if (done) begin
        got_done = 1'b1;
        check("pulses_at_done", p, 32'd11);
        check("enable_with_done", {31'd0, enable}, 32'd1);
      end
    end
    check("done_seen", {31'd0, got_done}, 32'd1);
    check("accepted_vectors", n, 32'd4);
    start = 1'b0; in_valid = 1'b0;
    tick();
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_enable", {31'd0, enable}, 32'd0);
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_enable"}, {31'd0, enable}, 32'd0);
    check({tag, "_weight"}, weightArray, 32'd0);
    check({tag, "_feature"}, featureArray, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b0; start = 1'b1; in_valid = 1'b1;
    in_weight = 32'h11223344; in_feature = 32'h55667788;

    // Reset held two cycles with start and valid asserted.
    tick();
    check("rst1_enable", {31'd0, enable}, 32'd0);
    tick();
    check_reset_state("rst2");
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    tick();
    check_reset_state("post_rst");

    // Back-to-back tile.
    run_tile(0, 1'b0);

    // Three-cycle input stall after vector 1.
    run_tile(3, 1'b0);

    // start held high through STREAM and FLUSH, then a clean second tile.
    run_tile(0, 1'b1);
    tick();
    check("no_second_done", {31'd0, done}, 32'd0);
    check("no_restart_busy", {31'd0, busy}, 32'd0);
    run_tile(0, 1'b0);

    // Reset after two accepted vectors aborts the tile.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_weight = mkvec(i, 1'b0); in_feature = mkvec(i, 1'b1);
      tick();
    end
    check("mid_lane0_weight", weightArray, exp_vec(1, 1'b0));
    rst = 1'b0; in_valid = 1'b1;
    tick();
    check_reset_state("mid_rst");
    rst = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("abort_no_done_%0d", i), {31'd0, done}, 32'd0);
      check($sformatf("abort_no_enable_%0d", i), {31'd0, enable}, 32'd0);
    end
    run_tile(0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sys_feeder.md
SYS_FEEDER -- requirements
Module: sys_feeder

Interface
REQ-001 SHALL have parameter dataWidth, default 32: bit width of one element.
REQ-002 SHALL have parameter SysDimension, default 32: number of lanes (rows/columns of the downstream systolic array).
REQ-003 SHALL have parameter featureLen, default 128: number of input vectors per tile.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on posedge clk.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port start, input, 1: begin tile; honoured only in IDLE.
REQ-007 SHALL have port in_valid, input, 1: input vector pair valid.
REQ-008 SHALL have port in_ready, output, 1: feeder accepts vector pair.
REQ-009 SHALL have port in_weight, input, dataWidth*SysDimension: weight vector, lane k at bits [(k+1)*dataWidth-1 : k*dataWidth].
REQ-010 SHALL have port in_feature, input, dataWidth*SysDimension: feature vector, same lane packing.
REQ-011 SHALL have port enable, output, 1: advance strobe to the systolic array.
REQ-012 SHALL have port weightArray, output, dataWidth*SysDimension: skewed weight lanes to the array.
REQ-013 SHALL have port featureArray, output, dataWidth*SysDimension: skewed feature lanes to the array.
REQ-014 SHALL have port busy, output, 1: high in STREAM and FLUSH.
REQ-015 SHALL have port done, output, 1: one-cycle pulse at tile completion.

Function
REQ-016 SHALL implement FSM states IDLE, STREAM, FLUSH, DONE.
REQ-017 SHALL go IDLE->STREAM on start=1; start outside IDLE is ignored.
REQ-018 SHALL drive in_ready=1 only in STREAM; a vector is accepted when in_valid&in_ready.
REQ-019 SHALL define "advance" = acceptance in STREAM, or every cycle in FLUSH.
REQ-020 SHALL count accepted vectors 0..featureLen-1; on the featureLen-th acceptance go STREAM->FLUSH next cycle.
REQ-021 SHALL in FLUSH perform exactly 2*SysDimension-1 advances injecting all-zero vectors, then go to DONE.
REQ-022 SHALL assert done for exactly the one DONE cycle, then return to IDLE.
REQ-023 SHALL hold per-lane skew registers: lane k (both weight and feature) delays by k advances, plus one output register stage.
REQ-024 SHALL update skew and output registers only on advance; with in_valid=0 in STREAM, registers and outputs hold.
REQ-025 SHALL register enable as the advance of the previous cycle: one enable pulse per advance, aligned with the new output data.
REQ-026 SHALL place element lane k of the n-th accepted vector on weightArray/featureArray lane k in the output cycle of the (n+k)-th advance (n from 0).
REQ-027 SHALL produce exactly featureLen+2*SysDimension-1 enable pulses per tile.
REQ-028 SHALL pass data unmodified (no arithmetic); lane 0 has zero added skew.

Reset
REQ-029 SHALL on rst=0 at a clock edge: state=IDLE, counters=0, all skew/output registers=0, enable=0, in_ready=0, busy=0, done=0.
REQ-030 SHALL abort any tile on reset mid-STREAM or mid-FLUSH with no done pulse; a new start after reset begins a fresh tile.

Verification (dataWidth=8, SysDimension=4, featureLen=4)
REQ-031 Reset held 2 cycles with in_valid=1, start=1 -> all outputs 0, no enable pulse.
REQ-032 start then 4 back-to-back vectors, lane k of vector n = 16*n+k -> 11 enable pulses; pulse p shows lane k = 16*(p-k)+k when 0<=p-k<=3, else 0; done one cycle after last FLUSH advance.
REQ-033 Same tile with in_valid low for 3 cycles after vector 1 -> outputs and enable frozen 3 cycles; data sequence per enable pulse identical to REQ-032.
REQ-034 start asserted during STREAM and FLUSH -> ignored; exactly one done; next start in IDLE runs a second tile correctly.
REQ-035 rst=0 after 2 accepted vectors -> outputs zero, no done; new tile afterwards matches REQ-032.
